// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - length-prefixed UART frame deframer with CRC-32 check and held output buffer
//
// Ports:
//   comm_clk       sole clock
//   rst_n          asynchronous active-low reset
//   rx_data        received byte, qualified by rx_valid
//   rx_valid       one-cycle strobe per received byte
//   frame_valid    committed frame pending, held until frame_ack
//   frame_ack      consumer releases the pending frame
//   frame_type     type byte of the pending frame
//   frame_words    payload word count of the pending frame
//   frame_payload  payload words, word k at [32k+31:32k], unused words zero
//   ping           one-cycle pulse when a zero length byte arrives in IDLE
//   err            one-cycle error pulse
//   err_code       1 BAD_LEN, 2 BAD_CRC, 3 TIMEOUT, 4 BAD_TYPE, 5 OVERRUN; holds last code
//   busy           a frame is being parsed

module uart_frame_rx #(
    parameter int          MAX_WORDS      = 13,
    parameter int          TIMEOUT_CYCLES = 2560,
    parameter int          CHECK_CRC      = 1,
    parameter logic [15:0] TYPE_MASK      = 16'h003F
) (
    input  logic                             comm_clk,
    input  logic                             rst_n,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             frame_valid,
    input  logic                             frame_ack,
    output logic [7:0]                       frame_type,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_words,
    output logic [32*MAX_WORDS-1:0]          frame_payload,
    output logic                             ping,
    output logic                             err,
    output logic [2:0]                       err_code,
    output logic                             busy
);

    localparam int WW      = $clog2(MAX_WORDS + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MAX_LEN = 8 + 4 * MAX_WORDS;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_CRC     = 2'd3;

    localparam logic [2:0] E_BAD_LEN  = 3'd1;
    localparam logic [2:0] E_BAD_CRC  = 3'd2;
    localparam logic [2:0] E_TIMEOUT  = 3'd3;
    localparam logic [2:0] E_BAD_TYPE = 3'd4;
    localparam logic [2:0] E_OVERRUN  = 3'd5;

    logic [1:0]    state;
    logic [1:0]    byte_cnt;
    logic [WW-1:0] nwords;
    logic [WW-1:0] word_idx;
    logic [23:0]   shift_q;     // first three bytes of the current payload word or CRC field
    logic [31:0]   crc_q;
    logic [7:0]    type_q;
    logic          type_bad;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   work_buf [MAX_WORDS];

    logic          len_bad;
    logic [31:0]   rx_word;
    logic          crc_ok;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        len_bad = (rx_data < 8'd8) || (rx_data[1:0] != 2'b00) || ({24'd0, rx_data} > 32'(MAX_LEN));
        rx_word = {rx_data, shift_q};
        crc_ok  = (rx_word == ~crc_q);
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            nwords        <= '0;
            word_idx      <= '0;
            shift_q       <= '0;
            crc_q         <= '0;
            type_q        <= '0;
            type_bad      <= 1'b0;
            tmo_cnt       <= '0;
            frame_valid   <= 1'b0;
            frame_type    <= '0;
            frame_words   <= '0;
            frame_payload <= '0;
            ping          <= 1'b0;
            err           <= 1'b0;
            err_code      <= '0;
            for (int k = 0; k < MAX_WORDS; k++) begin
                work_buf[k] <= '0;
            end
        end else begin
            ping <= 1'b0;
            err  <= 1'b0;

            // A commit later in this block overrides the release, so commit wins over ack.
            if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end

            if (state == S_IDLE || rx_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (state != S_IDLE && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                err      <= 1'b1;
                err_code <= E_TIMEOUT;
                state    <= S_IDLE;
            end else if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == 8'd0) begin
                            ping <= 1'b1;
                        end else if (len_bad) begin
                            err      <= 1'b1;
                            err_code <= E_BAD_LEN;
                        end else begin
                            nwords   <= WW'(rx_data[7:2] - 6'd2);
                            crc_q    <= crc_byte(32'hFFFFFFFF, rx_data);
                            byte_cnt <= '0;
                            state    <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        crc_q    <= crc_byte(crc_q, rx_data);
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt != 2'd2) begin
                            if (rx_data != 8'd0) begin
                                err      <= 1'b1;
                                err_code <= E_BAD_LEN;
                                state    <= S_IDLE;
                            end
                        end else begin
                            // Bad type is only flagged; the frame is still consumed to stay in sync.
                            type_q   <= rx_data;
                            type_bad <= (rx_data[7:4] != 4'd0) || !TYPE_MASK[rx_data[3:0]];
                            byte_cnt <= '0;
                            word_idx <= '0;
                            state    <= (nwords != '0) ? S_PAYLOAD : S_CRC;
                        end
                    end
                    S_PAYLOAD: begin
                        crc_q    <= crc_byte(crc_q, rx_data);
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {rx_data, shift_q[23:8]};
                        if (byte_cnt == 2'd3) begin
                            work_buf[word_idx] <= rx_word;
                            word_idx           <= word_idx + WW'(1);
                            if (word_idx == nwords - WW'(1)) begin
                                state <= S_CRC;
                            end
                        end
                    end
                    default: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {rx_data, shift_q[23:8]};
                        if (byte_cnt == 2'd3) begin
                            state <= S_IDLE;
                            if (type_bad) begin
                                err      <= 1'b1;
                                err_code <= E_BAD_TYPE;
                            end else if (CHECK_CRC != 0 && !crc_ok) begin
                                err      <= 1'b1;
                                err_code <= E_BAD_CRC;
                            end else if (frame_valid && !frame_ack) begin
                                err      <= 1'b1;
                                err_code <= E_OVERRUN;
                            end else begin
                                frame_valid <= 1'b1;
                                frame_type  <= type_q;
                                frame_words <= nwords;
                                for (int k = 0; k < MAX_WORDS; k++) begin
                                    frame_payload[32*k +: 32] <= (WW'(k) < nwords) ? work_buf[k] : 32'd0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed self-checking bench for uart_frame_rx

module tb_uart_frame_rx;

    localparam int MW  = 13;
    localparam int TMO = 2560;

    logic            clk;
    logic            rst_n;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_valid2;
    logic            frame_ack;
    logic            frame_ack2;

    logic            frame_valid, frame_valid2;
    logic [7:0]      frame_type, frame_type2;
    logic [3:0]      frame_words, frame_words2;
    logic [32*MW-1:0] frame_payload, frame_payload2;
    logic            ping, ping2;
    logic            err, err2;
    logic [2:0]      err_code, err_code2;
    logic            busy, busy2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frm [$];
    logic [31:0] wv  [MW];

    uart_frame_rx #(.MAX_WORDS(MW), .TIMEOUT_CYCLES(TMO), .CHECK_CRC(1), .TYPE_MASK(16'h003F)) u_dut (
        .comm_clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_type(frame_type),
        .frame_words(frame_words), .frame_payload(frame_payload), .ping(ping),
        .err(err), .err_code(err_code), .busy(busy)
    );

    uart_frame_rx #(.MAX_WORDS(MW), .TIMEOUT_CYCLES(TMO), .CHECK_CRC(0), .TYPE_MASK(16'h003F)) u_dut_nocrc (
        .comm_clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid2),
        .frame_valid(frame_valid2), .frame_ack(frame_ack2), .frame_type(frame_type2),
        .frame_words(frame_words2), .frame_payload(frame_payload2), .ping(ping2),
        .err(err2), .err_code(err_code2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] crc32_model(input logic [7:0] d [$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[n]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ d[n][i];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic make_frame(input logic [7:0] typ, input int nw);
        logic [31:0] c;
        frm.delete();
        frm.push_back(8'(8 + 4 * nw));
        frm.push_back(8'h00);
        frm.push_back(8'h00);
        frm.push_back(typ);
        for (int k = 0; k < nw; k++) begin
            for (int b = 0; b < 4; b++) frm.push_back(wv[k][8*b +: 8]);
        end
        c = crc32_model(frm);
        for (int b = 0; b < 4; b++) frm.push_back(c[8*b +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int tgt);
        @(negedge clk);
        rx_data = b;
        if (tgt == 0) rx_valid = 1'b1;
        else          rx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic send_frame(input int tgt, input bit flip_last);
        logic [7:0] b;
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            if (flip_last && i == frm.size() - 1) b = b ^ 8'hFF;
            send_byte(b, tgt);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_valid2 = 1'b0;
        frame_ack = 1'b0; frame_ack2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({frame_valid, ping, err, busy, err_code, frame_words, frame_type} !== 18'd0 || frame_payload !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got fv=%0b ping=%0b err=%0b busy=%0b code=%0d words=%0d type=%0h exp all 0",
                     frame_valid, ping, err, busy, err_code, frame_words, frame_type);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_crc_model;
        logic [7:0] s [$];
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        checks++;
        if (crc32_model(s) !== 32'hCBF43926) begin
            errors++;
            $display("FAIL crc_model_ref: got %08h exp cbf43926", crc32_model(s));
        end
    endtask

    task automatic test_ping;
        send_byte(8'h00, 0);
        checks++;
        if (ping !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL ping_pulse: got ping=%0b busy=%0b err=%0b fv=%0b exp 1 0 0 0", ping, busy, err, frame_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (ping !== 1'b0) begin
            errors++;
            $display("FAIL ping_one_cycle: got %0b exp 0", ping);
        end
    endtask

    task automatic test_get_info;
        make_frame(8'h00, 0);
        send_frame(0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || err !== 1'b0 || frame_type !== 8'h00 || frame_words !== 4'd0 || frame_payload !== '0) begin
            errors++;
            $display("FAIL get_info_commit: got fv=%0b err=%0b type=%0h words=%0d exp 1 0 00 0", frame_valid, err, frame_type, frame_words);
        end
        @(negedge clk); frame_ack = 1'b1;
        @(posedge clk); #1; frame_ack = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL get_info_ack: got fv=%0b exp 0", frame_valid);
        end
    endtask

    task automatic load_push_job_words;
        wv[0] = 32'h00000000;
        wv[1] = 32'hFFFFFFFF;
        for (int k = 2; k < MW; k++) wv[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endtask

    task automatic test_push_job;
        load_push_job_words();
        make_frame(8'h02, MW);
        send_frame(0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_type !== 8'h02 || frame_words !== 4'd13) begin
            errors++;
            $display("FAIL push_job_commit: got fv=%0b type=%0h words=%0d exp 1 02 13", frame_valid, frame_type, frame_words);
        end
        checks++;
        if (frame_payload[31:0] !== 32'h00000000 || frame_payload[63:32] !== 32'hFFFFFFFF ||
            frame_payload[95:64] !== 32'h0b0a0908 || frame_payload[32*12 +: 32] !== 32'h33323130) begin
            errors++;
            $display("FAIL push_job_words: got w0=%08h w1=%08h w2=%08h w12=%08h exp 00000000 ffffffff 0b0a0908 33323130",
                     frame_payload[31:0], frame_payload[63:32], frame_payload[95:64], frame_payload[32*12 +: 32]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frame_valid !== 1'b1 || frame_words !== 4'd13) begin
            errors++;
            $display("FAIL push_job_hold: got fv=%0b words=%0d exp 1 13", frame_valid, frame_words);
        end
        @(negedge clk); frame_ack = 1'b1;
        @(posedge clk); #1; frame_ack = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL push_job_ack: got fv=%0b exp 0", frame_valid);
        end
    endtask

    task automatic test_bad_len;
        logic [7:0] lens [3];
        lens = '{8'h06, 8'h0A, 8'h40};
        for (int i = 0; i < 3; i++) begin
            send_byte(lens[i], 0);
            checks++;
            if (err !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%0h: got err=%0b code=%0d busy=%0b exp 1 1 0", lens[i], err, err_code, busy);
            end
        end
        send_byte(8'h00, 0);
        checks++;
        if (ping !== 1'b1 || err !== 1'b0 || err_code !== 3'd1) begin
            errors++;
            $display("FAIL bad_len_then_ping: got ping=%0b err=%0b code=%0d exp 1 0 1", ping, err, err_code);
        end
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_reserved: got err=%0b code=%0d busy=%0b exp 1 1 0", err, err_code, busy);
        end
    endtask

    task automatic test_bad_crc;
        make_frame(8'h00, 0);
        send_frame(0, 1'b1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd2 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_crc: got err=%0b code=%0d fv=%0b exp 1 2 0", err, err_code, frame_valid);
        end
        send_frame(1, 1'b1);
        checks++;
        if (frame_valid2 !== 1'b1 || err2 !== 1'b0 || frame_words2 !== 4'd0) begin
            errors++;
            $display("FAIL nocrc_commit: got fv=%0b err=%0b words=%0d exp 1 0 0", frame_valid2, err2, frame_words2);
        end
    endtask

    task automatic test_timeout;
        int n;
        bit found;
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_before: got %0b exp 1", busy);
        end
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= TMO + 50 && !found; i++) begin
            @(posedge clk); #1;
            if (err) begin found = 1'b1; n = i; end
        end
        checks++;
        if (!found || n != TMO || err_code !== 3'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got found=%0b cycles=%0d code=%0d busy=%0b exp 1 %0d 3 0", found, n, err_code, busy, TMO);
        end
    endtask

    task automatic test_bad_type;
        make_frame(8'h07, 0);
        send_frame(0, 1'b0);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_type: got err=%0b code=%0d fv=%0b busy=%0b exp 1 4 0 0", err, err_code, frame_valid, busy);
        end
    endtask

    task automatic test_overrun;
        load_push_job_words();
        make_frame(8'h02, MW);
        send_frame(0, 1'b0);
        make_frame(8'h01, 0);
        send_frame(0, 1'b0);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd5) begin
            errors++;
            $display("FAIL overrun_err: got err=%0b code=%0d exp 1 5", err, err_code);
        end
        checks++;
        if (frame_valid !== 1'b1 || frame_type !== 8'h02 || frame_words !== 4'd13 || frame_payload[32*12 +: 32] !== 32'h33323130) begin
            errors++;
            $display("FAIL overrun_kept: got fv=%0b type=%0h words=%0d w12=%08h exp 1 02 13 33323130",
                     frame_valid, frame_type, frame_words, frame_payload[32*12 +: 32]);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_valid, ping, err, busy, err_code, frame_words, frame_type} !== 18'd0 || frame_payload !== '0) begin
            errors++;
            $display("FAIL reset_mid: got fv=%0b err=%0b busy=%0b code=%0d words=%0d type=%0h exp all 0",
                     frame_valid, err, busy, err_code, frame_words, frame_type);
        end
        @(negedge clk);
        rst_n = 1'b1;
        make_frame(8'h03, 0);
        send_frame(0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || err !== 1'b0 || frame_type !== 8'h03) begin
            errors++;
            $display("FAIL reset_restart: got fv=%0b err=%0b type=%0h exp 1 0 03", frame_valid, err, frame_type);
        end
    endtask

    initial begin
        test_reset();
        test_crc_model();
        test_ping();
        test_get_info();
        test_push_job();
        test_bad_len();
        test_bad_crc();
        test_timeout();
        test_bad_type();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
